mc_responder: RTL and testbench

MC_RESPONDER -- requirements
Module: mc_responder

---
 rtl/mc_responder_if.sv | 38 +++
 rtl/mc_responder.sv | 187 ++++++++++++++++++
 tb/tb_mc_responder.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/mc_responder_if.sv
// Request/response bus between a memory-controller requester and the mc_responder model.
// The master modport belongs to the requester, the slave modport to the responder.
interface mc_responder_if #(
    parameter int MC_RTNCTL_WIDTH = 32
);
    logic                       mc_rq_vld;
    logic [2:0]                 mc_rq_cmd;
    logic [3:0]                 mc_rq_scmd;
    logic [47:0]                mc_rq_vadr;
    logic [1:0]                 mc_rq_size;
    logic [MC_RTNCTL_WIDTH-1:0] mc_rq_rtnctl;
    logic [63:0]                mc_rq_data;
    logic                       mc_rq_flush;
    logic                       mc_rq_stall;

    logic                       mc_rs_vld;
    logic [2:0]                 mc_rs_cmd;
    logic [3:0]                 mc_rs_scmd;
    logic [MC_RTNCTL_WIDTH-1:0] mc_rs_rtnctl;
    logic [63:0]                mc_rs_data;
    logic                       mc_rs_stall;

    modport master (
        output mc_rq_vld, mc_rq_cmd, mc_rq_scmd, mc_rq_vadr, mc_rq_size,
               mc_rq_rtnctl, mc_rq_data, mc_rq_flush,
        input  mc_rq_stall,
        input  mc_rs_vld, mc_rs_cmd, mc_rs_scmd, mc_rs_rtnctl, mc_rs_data,
        output mc_rs_stall
    );

    modport slave (
        input  mc_rq_vld, mc_rq_cmd, mc_rq_scmd, mc_rq_vadr, mc_rq_size,
               mc_rq_rtnctl, mc_rq_data, mc_rq_flush,
        output mc_rq_stall,
        output mc_rs_vld, mc_rs_cmd, mc_rs_scmd, mc_rs_rtnctl, mc_rs_data,
        input  mc_rs_stall
    );
endinterface

// File: rtl/mc_responder.sv
// Memory-controller responder: 64-bit word memory, fixed-latency response pipeline
// and an in-order response FIFO with advisory stall, flush markers and sticky error flags.
module mc_responder #(
    parameter int MC_RTNCTL_WIDTH = 32,
    parameter int MEM_AW          = 10,
    parameter int LATENCY         = 4,
    parameter int FIFO_DEPTH      = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    mc_responder_if.slave               bus,
    output logic                        err_ovf,
    output logic                        err_cmd,
    output logic [$clog2(FIFO_DEPTH):0] outstanding
);
    localparam int FAW = $clog2(FIFO_DEPTH);
    localparam int OW  = FAW + 1;
    localparam int TW  = MC_RTNCTL_WIDTH;

    localparam logic [2:0] CMD_RD = 3'd1;
    localparam logic [2:0] CMD_WR = 3'd2;
    localparam logic [2:0] RS_RD  = 3'd2;
    localparam logic [2:0] RS_WR  = 3'd3;
    localparam logic [2:0] RS_FL  = 3'd4;

    typedef struct packed {
        logic [2:0]    cmd;
        logic [TW-1:0] tag;
        logic [63:0]   data;
    } rsp_t;

    // ---------------- request decode ----------------
    logic              cmd_ok;
    logic              take_rq;
    logic              take_fl;
    logic              ovf_hit;
    logic              entry_vld;
    logic              mem_we;
    logic [MEM_AW-1:0] widx;
    logic [OW-1:0]     outstanding_q;
    logic [OW-1:0]     outstanding_d;

    assign cmd_ok    = (bus.mc_rq_cmd == CMD_RD) || (bus.mc_rq_cmd == CMD_WR);
    assign take_rq   = bus.mc_rq_vld && cmd_ok;
    assign take_fl   = !bus.mc_rq_vld && bus.mc_rq_flush;
    // A full pipeline+FIFO discards the newcomer so queued responses stay intact.
    assign ovf_hit   = (take_rq || take_fl) && (outstanding_q == OW'(FIFO_DEPTH));
    assign entry_vld = (take_rq || take_fl) && !ovf_hit;
    assign mem_we    = entry_vld && take_rq && (bus.mc_rq_cmd == CMD_WR);
    assign widx      = bus.mc_rq_vadr[3 +: MEM_AW];

    logic unused_bits;
    assign unused_bits = ^{bus.mc_rq_scmd, bus.mc_rq_size,
                           bus.mc_rq_vadr[2:0], bus.mc_rq_vadr[47:3+MEM_AW]};

    // ---------------- word memory (not reset) ----------------
    logic [63:0] mem [0:(1<<MEM_AW)-1];
    logic [63:0] ram_rd_q;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[widx] <= bus.mc_rq_data;
        end
        ram_rd_q <= mem[widx];
    end

    // ---------------- response pipeline ----------------
    logic          st_vld  [0:LATENCY];
    logic [2:0]    st_cmd  [0:LATENCY];
    logic [TW-1:0] st_tag  [0:LATENCY];
    logic [63:0]   st_data [1:LATENCY];

    assign st_vld[0] = entry_vld;
    assign st_cmd[0] = take_fl ? RS_FL : ((bus.mc_rq_cmd == CMD_RD) ? RS_RD : RS_WR);
    assign st_tag[0] = take_fl ? '0 : bus.mc_rq_rtnctl;

    genvar gi;
    for (gi = 1; gi <= LATENCY; gi++) begin : g_stage
        logic          vld_q;
        logic [2:0]    cmd_q;
        logic [TW-1:0] tag_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= 1'b0;
            end else begin
                vld_q <= st_vld[gi-1];
            end
        end

        always_ff @(posedge clk) begin
            cmd_q <= st_cmd[gi-1];
            tag_q <= st_tag[gi-1];
        end

        assign st_vld[gi] = vld_q;
        assign st_cmd[gi] = cmd_q;
        assign st_tag[gi] = tag_q;

        // Stage 1 data is the memory's registered read port itself.
        if (gi == 1) begin : g_head
            assign st_data[gi] = (cmd_q == RS_RD) ? ram_rd_q : 64'd0;
        end else begin : g_body
            logic [63:0] data_q;
            always_ff @(posedge clk) begin
                data_q <= st_data[gi-1];
            end
            assign st_data[gi] = data_q;
        end
    end

    // ---------------- response FIFO ----------------
    rsp_t          fifo_mem [0:FIFO_DEPTH-1];
    rsp_t          push_rsp;
    rsp_t          head;
    logic [OW-1:0] wr_ptr_q;
    logic [OW-1:0] rd_ptr_q;
    logic          fifo_empty;
    logic          fifo_full;
    logic          fifo_push;
    logic          fifo_pop;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[FAW] != rd_ptr_q[FAW]) &&
                        (wr_ptr_q[FAW-1:0] == rd_ptr_q[FAW-1:0]);
    assign fifo_pop   = !fifo_empty && !bus.mc_rs_stall;
    assign fifo_push  = st_vld[LATENCY] && (!fifo_full || fifo_pop);

    assign push_rsp.cmd  = st_cmd[LATENCY];
    assign push_rsp.tag  = st_tag[LATENCY];
    assign push_rsp.data = st_data[LATENCY];
    assign head          = fifo_mem[rd_ptr_q[FAW-1:0]];

    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_mem[wr_ptr_q[FAW-1:0]] <= push_rsp;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (fifo_push) wr_ptr_q <= wr_ptr_q + OW'(1);
            if (fifo_pop)  rd_ptr_q <= rd_ptr_q + OW'(1);
        end
    end

    // ---------------- occupancy, stall, errors ----------------
    logic stall_q;
    logic err_ovf_q;
    logic err_cmd_q;

    always_comb begin
        outstanding_d = outstanding_q;
        if (entry_vld && !fifo_pop) begin
            outstanding_d = outstanding_q + OW'(1);
        end else if (!entry_vld && fifo_pop) begin
            outstanding_d = outstanding_q - OW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding_q <= '0;
            stall_q       <= 1'b0;
            err_ovf_q     <= 1'b0;
            err_cmd_q     <= 1'b0;
        end else begin
            outstanding_q <= outstanding_d;
            stall_q       <= (outstanding_q >= OW'(FIFO_DEPTH - 2));
            err_ovf_q     <= err_ovf_q | ovf_hit;
            err_cmd_q     <= err_cmd_q | (bus.mc_rq_vld && !cmd_ok);
        end
    end

    assign bus.mc_rq_stall  = stall_q;
    assign bus.mc_rs_vld    = fifo_pop;
    assign bus.mc_rs_cmd    = fifo_empty ? 3'd0 : head.cmd;
    assign bus.mc_rs_scmd   = 4'd0;
    assign bus.mc_rs_rtnctl = fifo_empty ? '0 : head.tag;
    assign bus.mc_rs_data   = fifo_empty ? 64'd0 : head.data;
    assign err_ovf          = err_ovf_q;
    assign err_cmd          = err_cmd_q;
    assign outstanding      = outstanding_q;
endmodule

// File: tb/tb_mc_responder.sv
// Directed bench for mc_responder: latency, address wrap, backpressure/overflow,
// flush ordering, illegal commands and asynchronous reset with memory retention.
module tb_mc_responder;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       err_ovf;
    logic       err_cmd;
    logic [4:0] outstanding;
    int         n_checks = 0;
    int         n_pass = 0;

    localparam logic [63:0] D40 = 64'hDEADBEEF_0000_0001;
    localparam logic [63:0] D48 = 64'h0123_4567_89AB_CDEF;

    always #5 clk = ~clk;

    mc_responder_if #(.MC_RTNCTL_WIDTH(32)) bus ();

    mc_responder #(
        .MC_RTNCTL_WIDTH(32),
        .MEM_AW(10),
        .LATENCY(4),
        .FIFO_DEPTH(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .err_ovf(err_ovf),
        .err_cmd(err_cmd),
        .outstanding(outstanding)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present one request for exactly one clock edge.
    task automatic req(input logic [2:0] cmd, input logic [47:0] adr,
                       input logic [31:0] tag, input logic [63:0] d);
        bus.mc_rq_vld    = 1'b1;
        bus.mc_rq_cmd    = cmd;
        bus.mc_rq_vadr   = adr;
        bus.mc_rq_rtnctl = tag;
        bus.mc_rq_data   = d;
        cyc();
        bus.mc_rq_vld    = 1'b0;
    endtask

    task automatic expect_rsp(input string tag, input logic [2:0] cmd,
                              input logic [31:0] rtn, input logic [63:0] d);
        int n = 0;
        while (bus.mc_rs_vld !== 1'b1 && n < 40) begin
            cyc();
            n++;
        end
        chk({tag, "_vld"}, 64'(bus.mc_rs_vld), 64'd1);
        $display("rsp %s: cmd=%0d rtnctl=%0d data=0x%h", tag, bus.mc_rs_cmd,
                 bus.mc_rs_rtnctl, bus.mc_rs_data);
        chk({tag, "_cmd"}, 64'(bus.mc_rs_cmd), 64'(cmd));
        chk({tag, "_rtn"}, 64'(bus.mc_rs_rtnctl), 64'(rtn));
        chk({tag, "_data"}, bus.mc_rs_data, d);
        cyc();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n            = 1'b0;
        bus.mc_rq_vld    = 1'b0;
        bus.mc_rq_cmd    = 3'd0;
        bus.mc_rq_scmd   = 4'd0;
        bus.mc_rq_vadr   = 48'd0;
        bus.mc_rq_size   = 2'd3;
        bus.mc_rq_rtnctl = 32'd0;
        bus.mc_rq_data   = 64'd0;
        bus.mc_rq_flush  = 1'b0;
        bus.mc_rs_stall  = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        chk("rst_outstanding", 64'(outstanding), 64'd0);
        chk("rst_rs_vld", 64'(bus.mc_rs_vld), 64'd0);
        chk("rst_rq_stall", 64'(bus.mc_rq_stall), 64'd0);
        chk("rst_err_ovf", 64'(err_ovf), 64'd0);
        chk("rst_err_cmd", 64'(err_cmd), 64'd0);
        chk("rst_rs_cmd", 64'(bus.mc_rs_cmd), 64'd0);
        chk("rst_rs_rtn", 64'(bus.mc_rs_rtnctl), 64'd0);
        rst_n = 1'b1;

        // Write then read, exact latency
        req(3'd2, 48'h40, 32'd5, D40);
        req(3'd1, 48'h40, 32'd6, 64'd0);
        chk("lat_outstanding", 64'(outstanding), 64'd2);
        cyc();
        cyc();
        chk("lat_early_vld", 64'(bus.mc_rs_vld), 64'd0);
        cyc();
        chk("lat_ontime_vld", 64'(bus.mc_rs_vld), 64'd1);
        expect_rsp("wr5", 3'd3, 32'd5, 64'd0);
        expect_rsp("rd6", 3'd2, 32'd6, D40);
        chk("lat_drained", 64'(outstanding), 64'd0);

        // Address wrap and ignored low bits
        req(3'd1, 48'h40, 32'd10, 64'd0);
        req(3'd1, 48'h2040, 32'd11, 64'd0);
        req(3'd2, 48'h2048, 32'd12, D48);
        req(3'd1, 48'h48, 32'd13, 64'd0);
        req(3'd1, 48'h47, 32'd14, 64'd0);
        expect_rsp("wrap_rd10", 3'd2, 32'd10, D40);
        expect_rsp("wrap_rd11", 3'd2, 32'd11, D40);
        expect_rsp("wrap_wr12", 3'd3, 32'd12, 64'd0);
        expect_rsp("wrap_rd13", 3'd2, 32'd13, D48);
        expect_rsp("wrap_rd14", 3'd2, 32'd14, D40);

        // Backpressure and overflow
        bus.mc_rs_stall = 1'b1;
        for (int i = 0; i < 17; i++) begin
            req(3'd1, 48'h40, 32'(100 + i), 64'd0);
            if (i == 13) begin
                chk("bp_out14", 64'(outstanding), 64'd14);
                chk("bp_stall_at14", 64'(bus.mc_rq_stall), 64'd0);
            end else if (i == 14) begin
                chk("bp_out15", 64'(outstanding), 64'd15);
                chk("bp_stall_after14", 64'(bus.mc_rq_stall), 64'd1);
            end else if (i == 15) begin
                chk("bp_out16", 64'(outstanding), 64'd16);
                chk("bp_no_ovf16", 64'(err_ovf), 64'd0);
            end else if (i == 16) begin
                chk("bp_ovf17", 64'(err_ovf), 64'd1);
                chk("bp_out_after17", 64'(outstanding), 64'd16);
            end
        end
        repeat (6) cyc();
        chk("bp_held_vld", 64'(bus.mc_rs_vld), 64'd0);
        chk("bp_held_out", 64'(outstanding), 64'd16);
        bus.mc_rs_stall = 1'b0;
        #1;
        for (int i = 0; i < 16; i++) begin
            expect_rsp($sformatf("bp_rd%0d", 100 + i), 3'd2, 32'(100 + i), D40);
        end
        chk("bp_drained", 64'(outstanding), 64'd0);
        chk("bp_drained_vld", 64'(bus.mc_rs_vld), 64'd0);
        chk("bp_stall_clear", 64'(bus.mc_rq_stall), 64'd0);

        // Flush ordering
        req(3'd2, 48'h80, 32'd1, 64'hA1);
        req(3'd2, 48'h88, 32'd2, 64'hA2);
        req(3'd2, 48'h90, 32'd3, 64'hA3);
        bus.mc_rq_flush = 1'b1;
        cyc();
        bus.mc_rq_flush = 1'b0;
        req(3'd1, 48'h80, 32'd7, 64'd0);
        expect_rsp("fl_wr1", 3'd3, 32'd1, 64'd0);
        expect_rsp("fl_wr2", 3'd3, 32'd2, 64'd0);
        expect_rsp("fl_wr3", 3'd3, 32'd3, 64'd0);
        expect_rsp("fl_flush", 3'd4, 32'd0, 64'd0);
        expect_rsp("fl_rd7", 3'd2, 32'd7, 64'hA1);

        // Flush alongside a valid request is ignored
        bus.mc_rq_flush = 1'b1;
        req(3'd1, 48'h88, 32'd8, 64'd0);
        bus.mc_rq_flush = 1'b0;
        chk("flv_out", 64'(outstanding), 64'd1);
        expect_rsp("flv_rd8", 3'd2, 32'd8, 64'hA2);
        repeat (6) cyc();
        chk("flv_no_flush_vld", 64'(bus.mc_rs_vld), 64'd0);
        chk("flv_out_zero", 64'(outstanding), 64'd0);

        // Illegal command
        chk("ic_before", 64'(err_cmd), 64'd0);
        req(3'd5, 48'h40, 32'd9, 64'd0);
        chk("ic_err_cmd", 64'(err_cmd), 64'd1);
        chk("ic_out", 64'(outstanding), 64'd0);
        repeat (6) cyc();
        chk("ic_no_rsp", 64'(bus.mc_rs_vld), 64'd0);

        // Reset with responses in flight; memory survives
        bus.mc_rs_stall = 1'b1;
        for (int i = 0; i < 6; i++) begin
            req(3'd1, 48'h40, 32'(20 + i), 64'd0);
        end
        chk("rr_out6", 64'(outstanding), 64'd6);
        repeat (5) cyc();
        bus.mc_rs_stall = 1'b0;
        #1;
        chk("rr_vld_before", 64'(bus.mc_rs_vld), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rr_vld_async", 64'(bus.mc_rs_vld), 64'd0);
        chk("rr_out_async", 64'(outstanding), 64'd0);
        chk("rr_err_ovf", 64'(err_ovf), 64'd0);
        chk("rr_err_cmd", 64'(err_cmd), 64'd0);
        chk("rr_stall", 64'(bus.mc_rq_stall), 64'd0);
        cyc();
        rst_n = 1'b1;
        req(3'd1, 48'h80, 32'd30, 64'd0);
        chk("rr_first_accept", 64'(outstanding), 64'd1);
        expect_rsp("rr_rd30", 3'd2, 32'd30, 64'hA1);
        repeat (2) cyc();
        chk("rr_final_out", 64'(outstanding), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
